interrupt_entry_sequencer: RTL
==============================

# interrupt_entry_sequencer

CPU-side responder for the timer interrupt controller. It accepts `irq`/`vector` at an instruction boundary, pushes the return PC onto the data-memory stack, and clears SREG.I and the serviced TIFR flag. It then redirects the PC to the ISR vector. It also executes the RETI exit sequence: pop the PC and set SREG.I. It sits between the interrupt controller, the fetch/PC logic, SP and the data-memory port.

## Interface
- `DATA_WIDTH`, 8, width of SREG/TIFR/SP/stack bytes
- `I_ADDR_WIDTH`, 10, PC/vector width; must satisfy I_ADDR_WIDTH <= 2*DATA_WIDTH
- `clk` in 1: the single clock; all state on its rising edge
- `reset` in 1: asynchronous, active-low reset
- `irq` in 1: registered request from the interrupt controller
- `vector` in I_ADDR_WIDTH: ISR address; valid while `irq`=1
- `instr_boundary` in 1: the CPU is between instructions and can be preempted
- `reti` in 1: a RETI has been decoded at this boundary
- `pc` in I_ADDR_WIDTH: return address (next instruction)
- `sp` in DATA_WIDTH: current stack pointer, owned by the CPU
- `mem_rdata` in DATA_WIDTH: stack read data; synchronous RAM, valid the cycle after `mem_re`
- `busy` out 1: high in every non-IDLE state; the CPU stalls fetch/execute
- `ack` out 1: one-cycle pulse on interrupt acceptance
- `mem_we`, `mem_re` out 1: stack write strobe and stack read strobe
- `mem_addr` out DATA_WIDTH; `mem_wdata` out DATA_WIDTH
- `sp_dec`, `sp_inc` out 1: the CPU applies SP∓1 at the end of the cycle
- `pc_load` out 1; `pc_target` out I_ADDR_WIDTH
- `sreg_i_clr`, `sreg_i_set` out 1: one-cycle pulses
- `tifr_clr` out DATA_WIDTH: one-hot write-1-to-clear mask

## Operation
- **States:** IDLE, PUSH_LO, PUSH_HI, JUMP, POP_HI, POP_LO, RET_LOAD.
- **IDLE priority:**
  - If `instr_boundary && reti`, go to POP_HI.
  - Else if `instr_boundary && irq`, capture `vector` to vec_q and `pc` to pc_q, then go to PUSH_LO.
  - Else stay in IDLE.
  - RETI therefore wins over a simultaneous irq. The irq is serviced at a later boundary.
- **PUSH_LO:**
  - `ack`=1, `sreg_i_clr`=1, `tifr_clr`=decode(vec_q).
  - `mem_we`=1, `mem_addr`=`sp`, `mem_wdata`=pc_q[7:0], `sp_dec`=1.
- **PUSH_HI:** `mem_we`=1, `mem_addr`=`sp` (already decremented), `mem_wdata`=pc_q upper bits zero-extended, `sp_dec`=1.
- **JUMP:** `pc_load`=1, `pc_target`=vec_q; then IDLE.
- **POP_HI:** `mem_re`=1, `mem_addr`=`sp`+1 (mod 2^DATA_WIDTH), `sp_inc`=1.
- **POP_LO:** capture `mem_rdata` to hi_q; `mem_re`=1, `mem_addr`=`sp`+1, `sp_inc`=1.
- **RET_LOAD:** `pc_load`=1, `pc_target`={hi_q, `mem_rdata`} truncated to I_ADDR_WIDTH, `sreg_i_set`=1; then IDLE.
- **Vector decode:**
  - `TIM0_OVF_ISR` maps to bit0, `TIM0_COMPA_ISR` to bit1, `TIM0_COMPB_ISR` to bit2.
  - Any other vector gives `tifr_clr`=0, but the jump still occurs.
- **Inputs ignored while busy:** `irq`, `reti`, `vector` and `instr_boundary`. Pending flags stay set in TIFR and re-request later.
- **Outputs:** all outputs are Moore decodes of state/regs. `pc_target` in RET_LOAD is the only path with `mem_rdata` combinational.
- **Stack wrap:** SP arithmetic wraps modulo 2^DATA_WIDTH; no overflow detection.

## Timing
- **Reset:**
  - Asserting `reset` low forces IDLE immediately and clears vec_q, pc_q and hi_q.
  - Every output is 0 while in reset and in IDLE.
  - Reset mid-sequence aborts it; partial stack writes are not undone.
- **Entry sequence** (irq sampled at edge n):
  - cycle n+1: PUSH_LO (`ack`)
  - cycle n+2: PUSH_HI
  - cycle n+3: JUMP (`pc_load`)
  - cycle n+4: IDLE, so the earliest next acceptance is the edge ending cycle n+4.
- **Exit sequence** (reti sampled at edge n): POP_HI in n+1, POP_LO in n+2, RET_LOAD in n+3.
- **Lagging irq:** the controller drops `irq` one cycle after `sreg_i_clr`. This is harmless because the block is already busy.

## Structure
- ISR vector macros already live in the shared `defines.vh`.
- Add the flag-bit indices there as `TIM0_OVF_BIT`, `TIM0_COMPA_BIT` and `TIM0_COMPB_BIT`.
- State encodings are local parameters.
- One sub-module is natural: `isr_flag_decoder`, a combinational vector to one-hot TIFR mask.

## Test plan
- **Interrupt entry:** `pc`=0x1A5, `sp`=0xFF, irq with `TIM0_OVF_ISR` at a boundary.
  - Expect mem[0xFF]=0xA5 and mem[0xFE]=0x01.
  - Expect `tifr_clr`=0x01, `sreg_i_clr` and `ack` in n+1, and `pc_load` with `pc_target`=`TIM0_OVF_ISR` in n+3.
- **RETI after that entry:** `sp`=0xFD.
  - Expect reads at 0xFE then 0xFF, two `sp_inc` pulses.
  - Expect `pc_target`=0x1A5 with `sreg_i_set` in n+3.
- **Simultaneous `reti` and `irq`:** the pop sequence runs with no `ack`. The irq is accepted at the first boundary after return.
- **`irq` without `instr_boundary`:** no action, `busy`=0. Acceptance occurs on the first boundary cycle.
- **`TIM0_COMPB_ISR` vector:** `tifr_clr`=0x04. An unknown vector gives `tifr_clr`=0x00 and still jumps.
- **Reset low during PUSH_HI:**
  - All outputs are 0 immediately.
  - After release the block is in IDLE and accepts a new irq normally.
  - SP wraps when `sp`=0x00 is pushed (second write at 0xFF).

Source files
------------

// File: rtl/interrupt_entry_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_entry_sequencer_pkg
// Shared definitions for the interrupt entry/exit sequencer:
//   - timer ISR vector addresses (word addresses in instruction memory)
//   - TIFR flag-bit indices serviced by each vector
//   - sequencer state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package interrupt_entry_sequencer_pkg;

  // ISR vector addresses for the timer interrupt controller.
  localparam int TIM0_COMPA_ISR = 'h01C;
  localparam int TIM0_COMPB_ISR = 'h01E;
  localparam int TIM0_OVF_ISR   = 'h020;

  // TIFR bit serviced by each vector; the sequencer clears it on entry.
  localparam int TIM0_OVF_BIT   = 0;
  localparam int TIM0_COMPA_BIT = 1;
  localparam int TIM0_COMPB_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_LO  = 3'd1,
    ST_PUSH_HI  = 3'd2,
    ST_JUMP     = 3'd3,
    ST_POP_HI   = 3'd4,
    ST_POP_LO   = 3'd5,
    ST_RET_LOAD = 3'd6
  } state_t;

endpackage

// File: rtl/interrupt_entry_sequencer_if.sv
// ----------------------------------------------------------------------------
// interrupt_entry_sequencer_if
// Bundles every signal between the sequencer and its neighbours (interrupt
// controller, fetch/PC logic, stack pointer and data-memory stack port).
//   slave  modport : the sequencer itself
//   master modport : the CPU / controller side
// Inputs to the sequencer : irq, vector, instr_boundary, reti, pc, sp,
//                           mem_rdata (sync RAM, valid the cycle after mem_re)
// Outputs of the sequencer: busy, ack, mem_we, mem_re, mem_addr, mem_wdata,
//                           sp_dec, sp_inc, pc_load, pc_target,
//                           sreg_i_clr, sreg_i_set, tifr_clr
// ----------------------------------------------------------------------------
interface interrupt_entry_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10
);

  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;
  logic                    instr_boundary;
  logic                    reti;
  logic [I_ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0]   sp;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  logic                    busy;
  logic                    ack;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    sp_dec;
  logic                    sp_inc;
  logic                    pc_load;
  logic [I_ADDR_WIDTH-1:0] pc_target;
  logic                    sreg_i_clr;
  logic                    sreg_i_set;
  logic [DATA_WIDTH-1:0]   tifr_clr;

  modport slave (
    input  irq, vector, instr_boundary, reti, pc, sp, mem_rdata,
    output busy, ack, mem_we, mem_re, mem_addr, mem_wdata, sp_dec, sp_inc,
           pc_load, pc_target, sreg_i_clr, sreg_i_set, tifr_clr
  );

  modport master (
    output irq, vector, instr_boundary, reti, pc, sp, mem_rdata,
    input  busy, ack, mem_we, mem_re, mem_addr, mem_wdata, sp_dec, sp_inc,
           pc_load, pc_target, sreg_i_clr, sreg_i_set, tifr_clr
  );

endinterface

// File: rtl/interrupt_entry_sequencer_isr_flag_decoder.sv
// ----------------------------------------------------------------------------
// interrupt_entry_sequencer_isr_flag_decoder
// Combinational map from an ISR vector address to the one-hot TIFR
// write-1-to-clear mask of the flag that vector services. Vectors that do not
// belong to a timer flag produce an all-zero mask.
//   vector : ISR address (I_ADDR_WIDTH)
//   mask   : one-hot TIFR clear mask (DATA_WIDTH)
// ----------------------------------------------------------------------------
module interrupt_entry_sequencer_isr_flag_decoder
  import interrupt_entry_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10
) (
  input  logic [I_ADDR_WIDTH-1:0] vector,
  output logic [DATA_WIDTH-1:0]   mask
);

  logic hit_ovf;
  logic hit_compa;
  logic hit_compb;

  assign hit_ovf   = (vector == I_ADDR_WIDTH'(TIM0_OVF_ISR));
  assign hit_compa = (vector == I_ADDR_WIDTH'(TIM0_COMPA_ISR));
  assign hit_compb = (vector == I_ADDR_WIDTH'(TIM0_COMPB_ISR));

  // Each mask bit is set only by the vector whose flag lives at that index;
  // the index comparisons fold away at elaboration.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign mask[gi] = ((gi == TIM0_OVF_BIT)   && hit_ovf)   ||
                      ((gi == TIM0_COMPA_BIT) && hit_compa) ||
                      ((gi == TIM0_COMPB_BIT) && hit_compb);
  end

endmodule

// File: rtl/interrupt_entry_sequencer.sv
// ----------------------------------------------------------------------------
// interrupt_entry_sequencer
// CPU-side responder for the timer interrupt controller.
//   Entry: at an instruction boundary with irq, push the return PC (low byte
//          first, then the zero-extended upper bits) onto the data-memory
//          stack, clear SREG.I and the serviced TIFR flag, then load the PC
//          with the ISR vector.
//   Exit : at a boundary with reti, pop the return PC (upper byte first) and
//          set SREG.I. RETI wins over a simultaneous irq.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : interrupt_entry_sequencer_if.slave (all handshake/stack/PC
//           signals)
// I_ADDR_WIDTH must not exceed 2*DATA_WIDTH (PC fits in two stack bytes).
// ----------------------------------------------------------------------------
module interrupt_entry_sequencer
  import interrupt_entry_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10
) (
  input logic                         clk,
  input logic                         reset,
  interrupt_entry_sequencer_if.slave  bus
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [I_ADDR_WIDTH-1:0] vec_q;
  logic [I_ADDR_WIDTH-1:0] vec_next;
  logic [I_ADDR_WIDTH-1:0] pc_q;
  logic [I_ADDR_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   hi_next;

  logic [DATA_WIDTH-1:0]   tifr_mask;
  logic [2*DATA_WIDTH-1:0] pc_ext;
  logic [2*DATA_WIDTH-1:0] ret_word;
  logic [DATA_WIDTH-1:0]   sp_plus_one;

  interrupt_entry_sequencer_isr_flag_decoder #(
    .DATA_WIDTH   (DATA_WIDTH),
    .I_ADDR_WIDTH (I_ADDR_WIDTH)
  ) u_isr_flag_decoder (
    .vector (vec_q),
    .mask   (tifr_mask)
  );

  // Return PC zero-extended to two stack bytes.
  assign pc_ext      = (2*DATA_WIDTH)'(pc_q);
  assign ret_word    = {hi_q, bus.mem_rdata};
  // Pops read the byte just above the current SP; wraps with SP width.
  assign sp_plus_one = bus.sp + DATA_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      vec_q     <= '0;
      pc_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_reg <= state_next;
      vec_q     <= vec_next;
      pc_q      <= pc_next;
      hi_q      <= hi_next;
    end
  end

  // Next state and captures. Requests are only looked at in IDLE, so
  // anything arriving mid-sequence waits for a later boundary.
  always_comb begin
    state_next = state_reg;
    vec_next   = vec_q;
    pc_next    = pc_q;
    hi_next    = hi_q;
    case (state_reg)
      ST_IDLE: begin
        if (bus.instr_boundary && bus.reti) begin
          state_next = ST_POP_HI;
        end else if (bus.instr_boundary && bus.irq) begin
          vec_next   = bus.vector;
          pc_next    = bus.pc;
          state_next = ST_PUSH_LO;
        end
      end
      ST_PUSH_LO:  state_next = ST_PUSH_HI;
      ST_PUSH_HI:  state_next = ST_JUMP;
      ST_JUMP:     state_next = ST_IDLE;
      ST_POP_HI:   state_next = ST_POP_LO;
      ST_POP_LO: begin
        // Read issued in POP_HI returns the upper byte now.
        hi_next    = bus.mem_rdata;
        state_next = ST_RET_LOAD;
      end
      ST_RET_LOAD: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Moore output decode; only pc_target in RET_LOAD sees mem_rdata directly.
  always_comb begin
    bus.busy       = (state_reg != ST_IDLE);
    bus.ack        = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.sp_dec     = 1'b0;
    bus.sp_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.pc_target  = '0;
    bus.sreg_i_clr = 1'b0;
    bus.sreg_i_set = 1'b0;
    bus.tifr_clr   = '0;
    case (state_reg)
      ST_PUSH_LO: begin
        bus.ack        = 1'b1;
        bus.sreg_i_clr = 1'b1;
        bus.tifr_clr   = tifr_mask;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = bus.sp;
        bus.mem_wdata  = pc_ext[DATA_WIDTH-1:0];
        bus.sp_dec     = 1'b1;
      end
      ST_PUSH_HI: begin
        // SP has already been decremented by the CPU after PUSH_LO.
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.sp;
        bus.mem_wdata = pc_ext[2*DATA_WIDTH-1:DATA_WIDTH];
        bus.sp_dec    = 1'b1;
      end
      ST_JUMP: begin
        bus.pc_load   = 1'b1;
        bus.pc_target = vec_q;
      end
      ST_POP_HI, ST_POP_LO: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = sp_plus_one;
        bus.sp_inc   = 1'b1;
      end
      ST_RET_LOAD: begin
        bus.pc_load    = 1'b1;
        bus.pc_target  = I_ADDR_WIDTH'(ret_word);
        bus.sreg_i_set = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
